// File: rtl/fifo_hs_stream_sync.sv
// Synchronous FIFO acting as slave on both push and pop req/ack interfaces.
// Each side runs either a one-word-per-req handshake or a combinational-ack stream.
module fifo_hs_stream_sync #(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       push_stream_mode,
   input  logic                       push_req,
   input  logic [WIDTH-1:0]           push_data_in,
   output logic                       push_ack,
   output logic                       push_ack_pulse,
   output logic                       fifo_full,
   input  logic                       pop_stream_mode,
   input  logic                       pop_req,
   output logic [WIDTH-1:0]           pop_data_out,
   output logic                       pop_ack,
   output logic                       pop_ack_pulse,
   output logic                       fifo_empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

   localparam logic [0:0] P_IDLE = 1'b0;
   localparam logic [0:0] P_ACK  = 1'b1;
   localparam logic [0:0] Q_IDLE = 1'b0;
   localparam logic [0:0] Q_ACK  = 1'b1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH < 0 || AF_THRESH > DEPTH ||
       AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_param_err
      $error("fifo_hs_stream_sync: illegal DEPTH or threshold parameter");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr, r_count;
   logic [0:0]       r_push_st, r_pop_st;
   logic             r_push_mode, r_pop_mode;
   logic             r_push_ack_hs, r_push_pulse_hs, r_pop_ack_hs, r_pop_pulse_hs;
   logic [WIDTH-1:0] r_pop_data;
   logic             r_full, r_empty, r_af, r_ae;

   logic             w_kill;
   logic             w_push_stream_ack, w_pop_stream_ack;
   logic             w_push_hs_go, w_pop_hs_go;
   logic             w_push, w_pop;
   logic [0:0]       w_push_st_nxt, w_pop_st_nxt;
   logic [PW-1:0]    w_wr_nxt, w_rd_nxt, w_count_nxt;
   logic             w_full_nxt, w_empty_nxt;

   // Acceptance decisions use the current registered flags only: no full/empty bypass.
   assign w_kill            = rstn | flush;
   assign w_push_stream_ack = r_push_mode & push_req & ~r_full & ~w_kill;
   assign w_pop_stream_ack  = r_pop_mode & pop_req & ~r_empty & ~w_kill;
   assign w_push_hs_go      = ~r_push_mode & (r_push_st == P_IDLE) & push_req & ~r_full & ~w_kill;
   assign w_pop_hs_go       = ~r_pop_mode & (r_pop_st == Q_IDLE) & pop_req & ~r_empty & ~w_kill;
   assign w_push            = w_push_stream_ack | w_push_hs_go;
   assign w_pop             = w_pop_stream_ack | w_pop_hs_go;

   always_comb begin
      w_push_st_nxt = r_push_st;
      w_pop_st_nxt  = r_pop_st;
      case (r_push_st)
         P_IDLE:  if (w_push_hs_go) w_push_st_nxt = P_ACK;
         P_ACK:   if (!push_req)    w_push_st_nxt = P_IDLE;
         default: w_push_st_nxt = P_IDLE;
      endcase
      case (r_pop_st)
         Q_IDLE:  if (w_pop_hs_go) w_pop_st_nxt = Q_ACK;
         Q_ACK:   if (!pop_req)    w_pop_st_nxt = Q_IDLE;
         default: w_pop_st_nxt = Q_IDLE;
      endcase
      w_wr_nxt    = r_wr_ptr + PW'(w_push);
      w_rd_nxt    = r_rd_ptr + PW'(w_pop);
      w_count_nxt = w_wr_nxt - w_rd_nxt;
      w_full_nxt  = (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) && (w_wr_nxt[AW] != w_rd_nxt[AW]);
      w_empty_nxt = (w_wr_nxt == w_rd_nxt);
   end

   always_ff @(posedge clk) begin
      if (w_kill) begin
         r_push_st       <= P_IDLE;
         r_pop_st        <= Q_IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_full          <= 1'b0;
         r_empty         <= 1'b1;
         r_af            <= 1'b0;
         r_ae            <= 1'b1;
         r_push_ack_hs   <= 1'b0;
         r_push_pulse_hs <= 1'b0;
         r_pop_ack_hs    <= 1'b0;
         r_pop_pulse_hs  <= 1'b0;
      end else begin
         r_push_st       <= w_push_st_nxt;
         r_pop_st        <= w_pop_st_nxt;
         r_wr_ptr        <= w_wr_nxt;
         r_rd_ptr        <= w_rd_nxt;
         r_count         <= w_count_nxt;
         r_full          <= w_full_nxt;
         r_empty         <= w_empty_nxt;
         r_af            <= (w_count_nxt >= AF_T);
         r_ae            <= (w_count_nxt <= AE_T);
         r_push_ack_hs   <= (w_push_st_nxt == P_ACK);
         r_push_pulse_hs <= w_push_hs_go;
         r_pop_ack_hs    <= (w_pop_st_nxt == Q_ACK);
         r_pop_pulse_hs  <= w_pop_hs_go;
      end
   end

   // Mode only changes while the side is idle with no request outstanding.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_push_mode <= 1'b0;
         r_pop_mode  <= 1'b0;
      end else begin
         if (r_push_st == P_IDLE && !push_req) r_push_mode <= push_stream_mode;
         if (r_pop_st == Q_IDLE && !pop_req)   r_pop_mode  <= pop_stream_mode;
      end
   end

   // Handshake pop data survives flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (rstn)             r_pop_data <= '0;
      else if (w_pop_hs_go) r_pop_data <= r_mem[r_rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_in;
   end

   assign push_ack       = r_push_mode ? w_push_stream_ack : r_push_ack_hs;
   assign push_ack_pulse = r_push_mode ? w_push_stream_ack : r_push_pulse_hs;
   assign pop_ack        = r_pop_mode  ? w_pop_stream_ack  : r_pop_ack_hs;
   assign pop_ack_pulse  = r_pop_mode  ? w_pop_stream_ack  : r_pop_pulse_hs;
   assign pop_data_out   = r_pop_mode  ? r_mem[r_rd_ptr[AW-1:0]] : r_pop_data;
   assign fifo_full      = r_full;
   assign fifo_empty     = r_empty;
   assign almost_full    = r_af;
   assign almost_empty   = r_ae;
   assign count          = r_count;

endmodule

// File: tb/tb_fifo_hs_stream_sync.sv
// Bench for fifo_hs_stream_sync: directed scenarios plus random traffic
// checked every cycle against a queue-based protocol model.
module tb_fifo_hs_stream_sync;

   localparam int WIDTH = 64;
   localparam int DEPTH = 16;
   localparam int AFT   = DEPTH - 2;
   localparam int AET   = 2;

   logic              clk = 1'b0;
   logic              rstn, flush;
   logic              push_stream_mode, push_req;
   logic [WIDTH-1:0]  push_data_in;
   logic              push_ack, push_ack_pulse, fifo_full;
   logic              pop_stream_mode, pop_req;
   logic [WIDTH-1:0]  pop_data_out;
   logic              pop_ack, pop_ack_pulse, fifo_empty;
   logic              almost_full, almost_empty;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   fifo_hs_stream_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .push_stream_mode(push_stream_mode), .push_req(push_req), .push_data_in(push_data_in),
      .push_ack(push_ack), .push_ack_pulse(push_ack_pulse), .fifo_full(fifo_full),
      .pop_stream_mode(pop_stream_mode), .pop_req(pop_req), .pop_data_out(pop_data_out),
      .pop_ack(pop_ack), .pop_ack_pulse(pop_ack_pulse), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_pp     = 0;

   // Reference model: contents as a queue, handshake sides as "acked this request" flags.
   logic [WIDTH-1:0] q[$];
   bit               m_push_mode, m_pop_mode;
   bit               m_push_busy, m_push_first, m_pop_busy, m_pop_first;
   logic [WIDTH-1:0] m_pop_data;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int sz    = q.size();
      bit kill  = rstn | flush;
      bit full  = (sz == DEPTH);
      bit empty = (sz == 0);
      bit e_pa  = m_push_mode ? (push_req & !full & !kill) : m_push_busy;
      bit e_pp  = m_push_mode ? (push_req & !full & !kill) : m_push_first;
      bit e_qa  = m_pop_mode  ? (pop_req & !empty & !kill) : m_pop_busy;
      bit e_qp  = m_pop_mode  ? (pop_req & !empty & !kill) : m_pop_first;
      chk("push_ack", WIDTH'(push_ack), WIDTH'(e_pa));
      chk("push_ack_pulse", WIDTH'(push_ack_pulse), WIDTH'(e_pp));
      chk("pop_ack", WIDTH'(pop_ack), WIDTH'(e_qa));
      chk("pop_ack_pulse", WIDTH'(pop_ack_pulse), WIDTH'(e_qp));
      chk("fifo_full", WIDTH'(fifo_full), WIDTH'(full));
      chk("fifo_empty", WIDTH'(fifo_empty), WIDTH'(empty));
      chk("almost_full", WIDTH'(almost_full), WIDTH'(sz >= AFT));
      chk("almost_empty", WIDTH'(almost_empty), WIDTH'(sz <= AET));
      chk("count", WIDTH'(count), WIDTH'(sz));
      if (!m_pop_mode)  chk("pop_data_hs", pop_data_out, m_pop_data);
      else if (!empty)  chk("pop_data_fwft", pop_data_out, q[0]);
      if (push_ack_pulse === 1'b1) n_pp++;
   endtask

   task automatic model_edge();
      int sz    = q.size();
      bit full  = (sz == DEPTH);
      bit empty = (sz == 0);
      bit do_push, do_pop, np, nq;
      logic [WIDTH-1:0] v;
      if (rstn) begin
         q.delete();
         m_push_mode = 0; m_pop_mode = 0;
         m_push_busy = 0; m_push_first = 0; m_pop_busy = 0; m_pop_first = 0;
         m_pop_data = '0;
      end else begin
         do_push = !flush && push_req && !full && (m_push_mode || !m_push_busy);
         do_pop  = !flush && pop_req && !empty && (m_pop_mode || !m_pop_busy);
         np = (!m_push_busy && !push_req) ? push_stream_mode : m_push_mode;
         nq = (!m_pop_busy && !pop_req) ? pop_stream_mode : m_pop_mode;
         if (flush) begin
            q.delete();
            m_push_busy = 0; m_push_first = 0; m_pop_busy = 0; m_pop_first = 0;
         end else begin
            if (do_pop) begin
               v = q.pop_front();
               if (!m_pop_mode) m_pop_data = v;
            end
            if (do_push) q.push_back(push_data_in);
            if (!m_push_mode) begin
               if (m_push_busy) begin
                  m_push_first = 0;
                  if (!push_req) m_push_busy = 0;
               end else if (do_push) begin
                  m_push_busy = 1; m_push_first = 1;
               end
            end
            if (!m_pop_mode) begin
               if (m_pop_busy) begin
                  m_pop_first = 0;
                  if (!pop_req) m_pop_busy = 0;
               end else if (do_pop) begin
                  m_pop_busy = 1; m_pop_first = 1;
               end
            end
         end
         m_push_mode = np;
         m_pop_mode  = nq;
      end
   endtask

   // One clock: check at negedge, advance the model, return just after posedge.
   task automatic cyc();
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rstn = 0; flush = 0; push_req = 0; pop_req = 0;
   endtask

   initial begin
      rstn = 1; flush = 0; push_stream_mode = 0; pop_stream_mode = 0;
      push_req = 1; pop_req = 0; push_data_in = 64'hDEAD;
      @(posedge clk);
      model_edge();
      #1;
      cyc();
      chk("reset_count", WIDTH'(count), 0);
      chk("reset_empty", WIDTH'(fifo_empty), 1);

      // Handshake push, request held four cycles per word.
      idle_inputs(); cyc();
      n_pp = 0;
      for (int i = 0; i < 3; i++) begin
         push_data_in = 64'hA1 + WIDTH'(i);
         push_req = 1;
         repeat (4) cyc();
         push_req = 0;
         cyc();
      end
      cyc();
      chk("hs3_pulses", WIDTH'(n_pp), 3);
      chk("hs3_count", WIDTH'(count), 3);
      chk("hs3_almost_empty", WIDTH'(almost_empty), 0);

      // Handshake pop back out.
      for (int i = 0; i < 3; i++) begin
         pop_req = 1; repeat (2) cyc();
         chk("hs_pop_data", pop_data_out, 64'hA1 + WIDTH'(i));
         pop_req = 0; cyc();
      end

      // Stream push to full, one extra refused attempt.
      push_stream_mode = 1; pop_stream_mode = 1; cyc();
      push_req = 1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_data_in = WIDTH'(i);
         cyc();
      end
      push_req = 0;
      chk("stream_full", WIDTH'(fifo_full), 1);
      chk("stream_full_count", WIDTH'(count), DEPTH);
      chk("stream_almost_full", WIDTH'(almost_full), 1);

      // Stream pop until empty plus one.
      pop_req = 1;
      repeat (DEPTH + 1) cyc();
      pop_req = 0;
      chk("stream_drain_empty", WIDTH'(fifo_empty), 1);

      // Full FIFO: stream push with handshake pop on the same edge.
      pop_stream_mode = 0; cyc();
      push_req = 1;
      for (int i = 0; i < DEPTH; i++) begin
         push_data_in = 64'h200 + WIDTH'(i);
         cyc();
      end
      push_data_in = 64'h300; pop_req = 1;
      repeat (2) cyc();
      push_req = 0; pop_req = 0;
      cyc();
      chk("swap_count", WIDTH'(count), DEPTH);
      chk("swap_pop_data", pop_data_out, 64'h200);

      // Pointer wrap: push 10, pop 10, push 12, drain.
      flush = 1; cyc(); flush = 0;
      pop_stream_mode = 1; cyc();
      push_req = 1;
      for (int i = 0; i < 10; i++) begin push_data_in = 64'h400 + WIDTH'(i); cyc(); end
      push_req = 0; pop_req = 1;
      repeat (10) cyc();
      pop_req = 0; push_req = 1;
      for (int i = 0; i < 12; i++) begin push_data_in = 64'h500 + WIDTH'(i); cyc(); end
      push_req = 0;
      chk("wrap_count", WIDTH'(count), 12);
      chk("wrap_head", pop_data_out, 64'h500);
      pop_req = 1;
      repeat (12) cyc();
      pop_req = 0;

      // Flush while a handshake pop sits in its ack phase.
      push_req = 1;
      for (int i = 0; i < 4; i++) begin push_data_in = 64'h600 + WIDTH'(i); cyc(); end
      push_req = 0; pop_stream_mode = 0; cyc();
      pop_req = 1; repeat (2) cyc();
      chk("qack_before_flush", WIDTH'(pop_ack), 1);
      flush = 1; cyc(); flush = 0;
      chk("flush_count", WIDTH'(count), 0);
      chk("flush_pop_ack", WIDTH'(pop_ack), 0);
      chk("flush_keeps_data", pop_data_out, 64'h600);
      repeat (2) cyc();
      chk("flush_rereq_no_ack", WIDTH'(pop_ack), 0);
      pop_req = 0; cyc();

      // Reset with a pending stream push.
      push_req = 1; push_data_in = 64'hBEEF; cyc();
      rstn = 1; cyc();
      rstn = 0; push_req = 0; cyc();
      chk("rst_push_count", WIDTH'(count), 0);
      chk("rst_push_ack", WIDTH'(push_ack), 0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rstn  = ($urandom_range(0, 399) == 0);
         flush = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 9) == 0) push_stream_mode = ~push_stream_mode;
         if ($urandom_range(0, 9) == 0) pop_stream_mode  = ~pop_stream_mode;
         push_req     = ($urandom_range(0, 99) < 60);
         pop_req      = ($urandom_range(0, 99) < 50);
         push_data_in = {$urandom, $urandom};
         cyc();
      end
      idle_inputs(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
